// File: rtl/joystick_spi_slave.sv
// SPI mode-0 slave emulating a joystick: returns a 40-bit position/button frame
// and accepts an LED command in the first received byte.
module joystick_spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic       cs,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [2:0] buttons,
  output logic [1:0] led,
  output logic       xfer_done,
  output logic       frame_err
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ACTIVE    = 2'd1;
  localparam logic [1:0] ST_WAIT_HIGH = 2'd2;

  localparam logic [1:0] SETTLE_CYCLES = 2'(SYNC_STAGES);
  localparam logic [5:0] FRAME_BITS    = 6'd40;
  localparam logic [5:0] CMD_BITS      = 6'd8;
  localparam logic [5:0] CNT_MAX       = 6'd63;

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_cs_d;
  logic                   r_sck_d;
  logic [1:0]             r_settle;

  logic [1:0]  r_state;
  logic [39:0] r_tx;
  logic [7:0]  r_rx;
  logic [5:0]  r_cnt;
  logic [1:0]  r_led;
  logic        r_xfer_done;
  logic        r_frame_err;

  logic        w_cs;
  logic        w_mosi;
  logic        w_cs_fall;
  logic        w_cs_rise;
  logic        w_sck_fall;
  logic        w_sck_rise;
  logic [39:0] w_tx_load;

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      r_cs_sync   <= '1;
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_cs_d      <= 1'b1;
      r_sck_d     <= 1'b0;
      r_settle    <= '0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
      r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
      // cs stages reset to ones; count until those have flushed so a cs held
      // low across reset release is not mistaken for an idle bus.
      if (r_settle != SETTLE_CYCLES) r_settle <= r_settle + 2'd1;
    end
  end

  always_comb begin
    w_cs       = r_cs_sync[SYNC_STAGES-1];
    w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    w_cs_fall  = r_cs_d & ~w_cs;
    w_cs_rise  = ~r_cs_d & w_cs;
    w_sck_fall = r_sck_d & ~r_sck_sync[SYNC_STAGES-1];
    w_sck_rise = ~r_sck_d & r_sck_sync[SYNC_STAGES-1];
    w_tx_load  = {x_pos[7:0], 6'b0, x_pos[9:8],
                  y_pos[7:0], 6'b0, y_pos[9:8],
                  5'b0, buttons};
  end

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      r_state     <= ST_WAIT_HIGH;
      r_tx        <= '0;
      r_rx        <= '0;
      r_cnt       <= '0;
      r_led       <= '0;
      r_xfer_done <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_xfer_done <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_WAIT_HIGH: begin
          if ((r_settle == SETTLE_CYCLES) && w_cs) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state <= ST_ACTIVE;
            r_tx    <= w_tx_load;
          end
        end
        ST_ACTIVE: begin
          if (w_cs_rise) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rx    <= '0;
            if (r_cnt == FRAME_BITS) r_xfer_done <= 1'b1;
            else                     r_frame_err <= 1'b1;
          end else begin
            if (w_sck_fall) r_tx <= {r_tx[38:0], 1'b0};
            if (w_sck_rise) begin
              r_rx <= {r_rx[6:0], w_mosi};
              if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 6'd1;
            end
          end
          // rx holds byte 0 for the whole cycle after the count reaches 8
          if ((r_cnt == CMD_BITS) && (r_rx[7:2] == 6'b100000)) r_led <= r_rx[1:0];
        end
        default: r_state <= ST_WAIT_HIGH;
      endcase
    end
  end

  always_comb begin
    miso      = (r_state == ST_ACTIVE) ? r_tx[39] : 1'b0;
    led       = r_led;
    xfer_done = r_xfer_done;
    frame_err = r_frame_err;
  end

endmodule

// File: tb/tb_joystick_spi_slave.sv
// Self-checking bench for joystick_spi_slave: directed scenarios plus random
// frames compared against a byte-level model of the joystick protocol.
module tb_joystick_spi_slave;

  logic       clk50M = 1'b0;
  logic       rst;
  logic       cs;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [2:0] buttons;
  logic [1:0] led;
  logic       xfer_done;
  logic       frame_err;

  int vectors     = 0;
  int miscompares = 0;
  int n_done      = 0;
  int n_err       = 0;
  logic [1:0] exp_led;

  joystick_spi_slave #(.SYNC_STAGES(2)) dut (
    .clk50M   (clk50M),
    .rst      (rst),
    .cs       (cs),
    .sck      (sck),
    .mosi     (mosi),
    .miso     (miso),
    .x_pos    (x_pos),
    .y_pos    (y_pos),
    .buttons  (buttons),
    .led      (led),
    .xfer_done(xfer_done),
    .frame_err(frame_err)
  );

  always #10 clk50M = ~clk50M;

  // Pulse monitor: a stretched pulse is counted more than once.
  always @(negedge clk50M) begin
    if (xfer_done === 1'b1) n_done++;
    if (frame_err === 1'b1) n_err++;
  end

  // Reference: five bytes, low 8 bits then high 2 bits of each axis, then buttons.
  function automatic logic [39:0] model_frame(input logic [9:0] x, input logic [9:0] y,
                                              input logic [2:0] b);
    logic [7:0] bytes [5];
    int xi, yi;
    xi = int'(x);
    yi = int'(y);
    bytes[0] = 8'(xi % 256);
    bytes[1] = 8'(xi / 256);
    bytes[2] = 8'(yi % 256);
    bytes[3] = 8'(yi / 256);
    bytes[4] = 8'(int'(b));
    return {bytes[0], bytes[1], bytes[2], bytes[3], bytes[4]};
  endfunction

  // Command bytes 0x80..0x83 set the LEDs once a full first byte has arrived.
  function automatic logic [1:0] model_led(input logic [1:0] prev, input int nbits,
                                           input logic [7:0] b0);
    if (nbits >= 8 && b0 >= 8'h80 && b0 <= 8'h83) return 2'(int'(b0) % 4);
    return prev;
  endfunction

  function automatic logic [47:0] top_mask(input int nbits);
    logic [47:0] ones;
    ones = '1;
    return ones << (48 - nbits);
  endfunction

  task automatic clock_bit(input logic b, input int half, output logic s);
    mosi = b;
    repeat (half) @(negedge clk50M);
    s = miso;
    sck = 1'b1;
    repeat (half) @(negedge clk50M);
    sck = 1'b0;
  endtask

  // Full master transaction; got holds sampled miso bits left-justified.
  task automatic run_frame(input int nbits, input logic [7:0] b0, input int half,
                           input int chg_bit, input logic [9:0] chg_x,
                           output logic [47:0] got);
    logic       s;
    logic [7:0] sh;
    logic       bv;
    got = '0;
    sh  = b0;
    @(negedge clk50M);
    cs = 1'b0;
    repeat (10) @(negedge clk50M);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) x_pos = chg_x;
      if (i < 8) begin
        bv = sh[7];
        sh = sh << 1;
      end else begin
        bv = 1'($urandom);
      end
      clock_bit(bv, half, s);
      got = {got[46:0], s};
    end
    got = got << (48 - nbits);
    repeat (half) @(negedge clk50M);
    cs = 1'b1;
    repeat (12) @(negedge clk50M);
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    x_pos = '0; y_pos = '0; buttons = '0;
    repeat (3) @(negedge clk50M);
    vectors++;
    if (miso !== 1'b0) begin miscompares++; $display("FAIL reset_miso: got %b expected 0", miso); end
    vectors++;
    if (led !== 2'b00) begin miscompares++; $display("FAIL reset_led: got %b expected 00", led); end
    vectors++;
    if (xfer_done !== 1'b0 || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pulses: got done=%b err=%b expected 0/0", xfer_done, frame_err);
    end
    rst = 1'b0;
    exp_led = 2'b00;
    repeat (10) @(negedge clk50M);
  endtask

  task automatic test_basic();
    logic [47:0] got;
    logic [7:0]  exp_b [5];
    logic [7:0]  got_b;
    int d0, e0;
    exp_b = '{8'hF0, 8'h02, 8'hA0, 8'h00, 8'h05};
    x_pos = 10'h2F0; y_pos = 10'h0A0; buttons = 3'b101;
    d0 = n_done; e0 = n_err;
    run_frame(40, 8'h83, 25, -1, 10'h0, got);
    for (int k = 0; k < 5; k++) begin
      got_b = got[47 - 8*k -: 8];
      vectors++;
      if (got_b !== exp_b[k]) begin
        miscompares++;
        $display("FAIL basic_byte%0d: got %h expected %h", k, got_b, exp_b[k]);
      end
    end
    exp_led = 2'b11;
    vectors++;
    if (led !== exp_led) begin miscompares++; $display("FAIL basic_led: got %b expected %b", led, exp_led); end
    vectors++;
    if ((n_done - d0) !== 1 || (n_err - e0) !== 0) begin
      miscompares++;
      $display("FAIL basic_pulses: got done=%0d err=%0d expected 1/0", n_done - d0, n_err - e0);
    end
  endtask

  task automatic test_midframe_change();
    logic [47:0] got;
    x_pos = 10'h2F0; y_pos = 10'h0A0; buttons = 3'b101;
    run_frame(40, 8'h00, 6, 16, 10'h3FF, got);
    vectors++;
    if (got[47:32] !== 16'hF002) begin
      miscompares++;
      $display("FAIL midframe_current: got %h expected F002", got[47:32]);
    end
    run_frame(40, 8'h00, 6, -1, 10'h0, got);
    vectors++;
    if (got[47:32] !== 16'hFF03) begin
      miscompares++;
      $display("FAIL midframe_next: got %h expected FF03", got[47:32]);
    end
    vectors++;
    if (led !== exp_led) begin miscompares++; $display("FAIL midframe_led: got %b expected %b", led, exp_led); end
  endtask

  task automatic test_led_cmds();
    logic [47:0] got;
    run_frame(40, 8'h41, 6, -1, 10'h0, got);
    vectors++;
    if (led !== 2'b11) begin miscompares++; $display("FAIL led_41: got %b expected 11", led); end
    run_frame(40, 8'h81, 6, -1, 10'h0, got);
    exp_led = 2'b01;
    vectors++;
    if (led !== 2'b01) begin miscompares++; $display("FAIL led_81: got %b expected 01", led); end
  endtask

  task automatic test_abort();
    logic [47:0] got, expv, m;
    int d0, e0;
    x_pos = 10'($urandom); y_pos = 10'($urandom); buttons = 3'($urandom);
    expv = {model_frame(x_pos, y_pos, buttons), 8'h00};
    d0 = n_done; e0 = n_err;
    run_frame(12, 8'h82, 6, -1, 10'h0, got);
    m = top_mask(12);
    exp_led = 2'b10;
    vectors++;
    if ((got & m) !== (expv & m)) begin miscompares++; $display("FAIL abort_data: got %h expected %h", got & m, expv & m); end
    vectors++;
    if (led !== exp_led) begin miscompares++; $display("FAIL abort_led: got %b expected %b", led, exp_led); end
    vectors++;
    if ((n_done - d0) !== 0 || (n_err - e0) !== 1) begin
      miscompares++;
      $display("FAIL abort_pulses: got done=%0d err=%0d expected 0/1", n_done - d0, n_err - e0);
    end
    d0 = n_done; e0 = n_err;
    run_frame(40, 8'h00, 6, -1, 10'h0, got);
    vectors++;
    if (got[47:8] !== expv[47:8] || (n_done - d0) !== 1 || (n_err - e0) !== 0) begin
      miscompares++;
      $display("FAIL abort_recover: got %h done=%0d err=%0d expected %h 1/0",
               got[47:8], n_done - d0, n_err - e0, expv[47:8]);
    end
    d0 = n_done; e0 = n_err;
    run_frame(44, 8'h00, 5, -1, 10'h0, got);
    vectors++;
    if (got[47:8] !== expv[47:8] || got[7:4] !== 4'h0 || (n_err - e0) !== 1 || (n_done - d0) !== 0) begin
      miscompares++;
      $display("FAIL overrun: got %h err=%0d done=%0d expected %h0 1/0",
               got[47:4], n_err - e0, n_done - d0, expv[47:8]);
    end
  endtask

  task automatic test_reset_midframe();
    logic [47:0] got;
    logic s, any_hi;
    int d0, e0;
    @(negedge clk50M);
    cs = 1'b0;
    repeat (10) @(negedge clk50M);
    clock_bit(1'b1, 6, s);
    for (int i = 1; i < 6; i++) clock_bit(1'b0, 6, s);
    for (int i = 6; i < 20; i++) clock_bit(1'b1, 6, s);
    vectors++;
    if (led !== 2'b11) begin miscompares++; $display("FAIL rstmid_led_before: got %b expected 11", led); end
    d0 = n_done; e0 = n_err;
    rst = 1'b1;
    #1;
    exp_led = 2'b00;
    vectors++;
    if (miso !== 1'b0 || led !== 2'b00) begin
      miscompares++;
      $display("FAIL rstmid_immediate: got miso=%b led=%b expected 0/00", miso, led);
    end
    repeat (3) @(negedge clk50M);
    rst = 1'b0;
    any_hi = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clock_bit(1'($urandom), 6, s);
      any_hi = any_hi | s;
    end
    cs = 1'b1;
    repeat (12) @(negedge clk50M);
    vectors++;
    if (any_hi !== 1'b0 || (n_done - d0) !== 0 || (n_err - e0) !== 0 || led !== 2'b00) begin
      miscompares++;
      $display("FAIL rstmid_ignored: got miso_any=%b done=%0d err=%0d led=%b expected 0/0/0/00",
               any_hi, n_done - d0, n_err - e0, led);
    end
    x_pos = 10'h155; y_pos = 10'h2AA; buttons = 3'b011;
    d0 = n_done;
    run_frame(40, 8'h81, 8, -1, 10'h0, got);
    exp_led = 2'b01;
    vectors++;
    if (got[47:8] !== model_frame(10'h155, 10'h2AA, 3'b011) || led !== 2'b01 || (n_done - d0) !== 1) begin
      miscompares++;
      $display("FAIL rstmid_after: got %h led=%b done=%0d expected %h 01 1",
               got[47:8], led, n_done - d0, model_frame(10'h155, 10'h2AA, 3'b011));
    end
  endtask

  task automatic test_cs_high_sck();
    logic any_hi;
    int d0, e0;
    d0 = n_done; e0 = n_err;
    any_hi = 1'b0;
    cs = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mosi = 1'($urandom);
      repeat (5) begin @(negedge clk50M); any_hi = any_hi | miso; end
      sck = 1'b1;
      repeat (5) begin @(negedge clk50M); any_hi = any_hi | miso; end
      sck = 1'b0;
    end
    repeat (10) @(negedge clk50M);
    vectors++;
    if (any_hi !== 1'b0 || led !== exp_led || (n_done - d0) !== 0 || (n_err - e0) !== 0) begin
      miscompares++;
      $display("FAIL cs_high_sck: got miso_any=%b led=%b done=%0d err=%0d expected 0 %b 0 0",
               any_hi, led, n_done - d0, n_err - e0, exp_led);
    end
  endtask

  task automatic test_random();
    logic [47:0] got, expv, m;
    logic [7:0]  b0;
    int nbits, half, chg, d0, e0, exp_d, exp_e;
    for (int it = 0; it < 10; it++) begin
      x_pos = 10'($urandom); y_pos = 10'($urandom); buttons = 3'($urandom);
      b0    = ($urandom_range(0, 1) == 1) ? 8'(8'h80 + 8'($urandom_range(0, 3))) : 8'($urandom);
      nbits = ($urandom_range(0, 2) != 0) ? 40 : int'($urandom_range(1, 47));
      half  = int'($urandom_range(5, 12));
      chg   = int'($urandom_range(0, 47));
      expv  = {model_frame(x_pos, y_pos, buttons), 8'h00};
      exp_led = model_led(exp_led, nbits, b0);
      exp_d = (nbits == 40) ? 1 : 0;
      exp_e = 1 - exp_d;
      d0 = n_done; e0 = n_err;
      run_frame(nbits, b0, half, chg, 10'($urandom), got);
      m = top_mask(nbits);
      vectors++;
      if ((got & m) !== (expv & m)) begin
        miscompares++;
        $display("FAIL rand%0d_data: got %h expected %h (nbits=%0d)", it, got & m, expv & m, nbits);
      end
      vectors++;
      if (led !== exp_led) begin
        miscompares++;
        $display("FAIL rand%0d_led: got %b expected %b (b0=%h nbits=%0d)", it, led, exp_led, b0, nbits);
      end
      vectors++;
      if ((n_done - d0) !== exp_d) begin
        miscompares++;
        $display("FAIL rand%0d_done: got %0d expected %0d", it, n_done - d0, exp_d);
      end
      vectors++;
      if ((n_err - e0) !== exp_e) begin
        miscompares++;
        $display("FAIL rand%0d_err: got %0d expected %0d", it, n_err - e0, exp_e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midframe_change();
    test_led_cmds();
    test_abort();
    test_reset_midframe();
    test_cs_high_sck();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/joystick_spi_slave.md
JOYSTICK_SPI_SLAVE -- requirements
Module: joystick_spi_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for cs, sck and mosi; legal values are 2..3.
REQ-002 Port clk50M, input, 1: system clock, 50 MHz.
REQ-003 Port rst, input, 1: reset, asynchronous, active-high.
REQ-004 Port cs, input, 1: SPI chip select from the master, active-low; asynchronous to clk50M.
REQ-005 Port sck, input, 1: SPI clock from the master, mode 0 (idle low); asynchronous to clk50M.
REQ-006 Port mosi, input, 1: master-out data; asynchronous to clk50M.
REQ-007 Port miso, output, 1: slave-out data, MSB first.
REQ-008 Port x_pos, input, 10: emulated X position, range 0..1023.
REQ-009 Port y_pos, input, 10: emulated Y position, range 0..1023.
REQ-010 Port buttons, input, 3: emulated buttons {btn2, btn1, trigger}.
REQ-011 Port led, output, 2: {LD2, LD1} as commanded by the master.
REQ-012 Port xfer_done, output, 1: one-cycle pulse when a complete 40-bit frame ends.
REQ-013 Port frame_err, output, 1: one-cycle pulse when cs deasserts with a bit count other than 40.

Function
REQ-014 cs, sck and mosi SHALL each pass through SYNC_STAGES flops before use; edges SHALL be detected from the last synchronized stage against one further delay flop.
REQ-015 The state machine SHALL have three states: IDLE, ACTIVE and WAIT_HIGH.
REQ-016 IDLE -> ACTIVE SHALL occur on a synchronized cs falling edge.
REQ-017 ACTIVE -> IDLE SHALL occur on a synchronized cs rising edge.
REQ-018 After reset the block SHALL enter WAIT_HIGH and move to IDLE only once synchronized cs has been sampled high; a transfer already in progress at reset release is ignored.
REQ-019 On entering ACTIVE, the block SHALL snapshot a 40-bit tx register in one cycle, MSB first: {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8], 5'b0, buttons}.
REQ-020 Input changes during ACTIVE SHALL NOT affect the frame in flight.
REQ-021 miso SHALL equal tx[39] while in ACTIVE, and 0 otherwise.
REQ-022 On each synchronized sck falling edge in ACTIVE, tx SHALL shift left by one with 0 filled in.
REQ-023 On each synchronized sck rising edge in ACTIVE, mosi SHALL be shifted into an 8-bit rx register (LSB in), and a 6-bit bit counter SHALL increment, saturating at 63.
REQ-024 When the bit counter reaches 8, if rx[7:2] == 6'b100000 then led SHALL load rx[1:0] on the following cycle; otherwise led is unchanged.
REQ-025 Bytes 2..5 received from the master SHALL be ignored.
REQ-026 Latency: miso SHALL reflect a new bit within SYNC_STAGES+2 clk50M cycles of the sck falling edge or the cs falling edge.
REQ-027 Supported sck SHALL be at most clk50M/8 (6.25 MHz) with a high and low time of at least 4 cycles each; the master SHALL wait at least 6 cycles after the cs falling edge before the first sck rising edge.
REQ-028 On the cs rising edge, if the count is exactly 40 then xfer_done SHALL pulse for one cycle; otherwise frame_err SHALL pulse for one cycle.
REQ-029 On the cs rising edge the count and rx SHALL clear.
REQ-030 An abort before byte 1 completes SHALL leave led unchanged.
REQ-031 More than 40 sck edges SHALL shift out zeros and set frame_err at cs high.
REQ-032 sck edges while cs is high SHALL be ignored.
REQ-033 If the cs falling edge and an sck edge are seen in the same cycle, the sck edge SHALL be ignored.

Reset
REQ-034 While rst is high: miso=0, led=2'b00, xfer_done=0, frame_err=0, tx=0, rx=0, count=0, state=WAIT_HIGH, and synchronizer flops cleared with cs stages set to 1.
REQ-035 rst SHALL take effect asynchronously; release SHALL be used synchronously with clk50M.

Verification
REQ-036 x_pos=10'h2F0, y_pos=10'h0A0, buttons=3'b101, sck=1 MHz, 40-bit frame with MOSI byte 0 = 8'h83 -> miso bytes 8'hF0, 8'h02, 8'hA0, 8'h00, 8'h05; led=2'b11; one xfer_done pulse; no frame_err.
REQ-037 Change x_pos to 10'h3FF in the middle of a frame -> the current frame still returns 8'hF0, 8'h02; the next frame returns 8'hFF, 8'h03.
REQ-038 MOSI byte 0 = 8'h41 -> led unchanged.
REQ-039 MOSI byte 0 = 8'h81 -> led=2'b01.
REQ-040 cs raised after 12 bits -> frame_err pulses once, led is updated from byte 0, and a following full frame succeeds.
REQ-041 rst asserted after bit 20 while cs stays low -> miso=0 and led=0 immediately; no response until cs goes high and falls again; then a normal frame follows.
REQ-042 sck toggled 10 times with cs high -> miso stays 0, led unchanged, no pulses.
